// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin shared-ALU block:
// opcodes, FSM state encoding and default widths.
package alu_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int OPW_DEF   = 4;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

endpackage

// File: rtl/alu_exec.sv
// Combinational ALU: add/sub/and/or with zero flag.
// Unknown opcodes return zero result with err set.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OPW-1:0]   op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             err_o
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(ALU_ADD);
  localparam logic [OPW-1:0] OP_SUB = OPW'(ALU_SUB);
  localparam logic [OPW-1:0] OP_AND = OPW'(ALU_AND);
  localparam logic [OPW-1:0] OP_OR  = OPW'(ALU_OR);

  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    unique case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      default: err_o = 1'b1;
    endcase
  end

  assign zero_o = !err_o && (result_o == '0);

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-client round-robin front end for one shared ALU.
// One operation in flight: IDLE -> EXEC -> RESP.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [OPW-1:0]   op_q;
  logic             zero_q, err_q;

  logic             gnt, acc, rsp_rdy;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero, alu_err;

  alu_exec #(
    .WIDTH(WIDTH),
    .OPW  (OPW)
  ) u_alu (
    .a_i     (a_q),
    .b_i     (b_q),
    .op_i    (op_q),
    .result_o(alu_res),
    .zero_o  (alu_zero),
    .err_o   (alu_err)
  );

  // Pointer only breaks ties; a lone valid requester always wins.
  assign gnt     = (req0_valid && req1_valid) ? ptr_q : req1_valid;
  assign rsp_rdy = id_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    acc        = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            acc        = 1'b1;
            req0_ready = !gnt;
            req1_ready = gnt;
            state_d    = EXEC;
          end
        end
        EXEC: state_d = RESP;
        RESP: begin
          rsp0_valid = !id_q;
          rsp1_valid = id_q;
          if (rsp_rdy) begin
            state_d = IDLE;
            ptr_d   = !id_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (acc) begin
        id_q <= gnt;
        a_q  <= gnt ? req1_a : req0_a;
        b_q  <= gnt ? req1_b : req0_b;
        op_q <= gnt ? req1_op : req0_op;
      end
      if (state_q == EXEC) begin
        res_q  <= alu_res;
        zero_q <= alu_zero;
        err_q  <= alu_err;
      end
    end
  end

  assign rsp0_result = res_q;
  assign rsp0_zero   = zero_q;
  assign rsp0_err    = err_q;
  assign rsp1_result = res_q;
  assign rsp1_zero   = zero_q;
  assign rsp1_err    = err_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: transaction-level model checked every
// cycle, plus literal expectations on selected responses.
module tb_alu_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [63:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;

  always #5 clk = ~clk;

  alu_rr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_result(rsp0_result),
    .rsp0_zero  (rsp0_zero),
    .rsp0_err   (rsp0_err),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_result(rsp1_result),
    .rsp1_zero  (rsp1_zero),
    .rsp1_err   (rsp1_err)
  );

  int checks = 0;
  int errors = 0;

  // Model: one transaction, age counts edges since acceptance.
  logic        m_busy = 1'b0;
  logic        m_id   = 1'b0;
  logic        m_ptr  = 1'b0;
  int          m_age  = 0;
  logic [63:0] m_res  = '0;
  logic        m_zero = 1'b0;
  logic        m_err  = 1'b0;

  // Literal expectations armed by the stimulus.
  int          lit_seq = 0, lit_done = 0;
  logic        lit_ch = 1'b0;
  logic [63:0] lit_res = '0;
  logic        lit_zero = 1'b0, lit_err = 1'b0;
  int          tmo_cnt = 0, tmo_seen = 0;

  function automatic logic legal(input logic [3:0] op);
    return op == 4'd2 || op == 4'd6 || op == 4'd0 || op == 4'd1;
  endfunction

  function automatic logic [63:0] ref_res(input logic [63:0] a, b,
                                          input logic [3:0] op);
    if (op == 4'd2) return a + b;
    if (op == 4'd6) return a - b;
    if (op == 4'd0) return a & b;
    if (op == 4'd1) return a | b;
    return 64'd0;
  endfunction

  function automatic logic winner(input logic v0, v1, p);
    if (v0 && v1) return p;
    if (v0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    logic        g;
    logic [63:0] a, b;
    logic [3:0]  op;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 1'b0;
        m_ptr  = 1'b0;
      end else if (!m_busy) begin
        if (req0_valid || req1_valid) begin
          g      = winner(req0_valid, req1_valid, m_ptr);
          a      = g ? req1_a : req0_a;
          b      = g ? req1_b : req0_b;
          op     = g ? req1_op : req0_op;
          m_id   = g;
          m_err  = !legal(op);
          m_res  = ref_res(a, b, op);
          m_zero = !m_err && m_res == 64'd0;
          m_busy = 1'b1;
          m_age  = 1;
        end
      end else if (m_age < 2) begin
        m_age = m_age + 1;
      end else if (m_id ? rsp1_ready : rsp0_ready) begin
        m_busy = 1'b0;
        m_ptr  = !m_id;
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", n, got, want, $time);
    end
  endtask

  initial begin
    logic any, g, rv;
    forever begin
      @(negedge clk);
      any = req0_valid || req1_valid;
      g   = winner(req0_valid, req1_valid, m_ptr);
      rv  = !rst && m_busy && m_age >= 2;
      chk("req0_ready", 64'(req0_ready), 64'(!rst && !m_busy && any && !g));
      chk("req1_ready", 64'(req1_ready), 64'(!rst && !m_busy && any && g));
      chk("rsp0_valid", 64'(rsp0_valid), 64'(rv && !m_id));
      chk("rsp1_valid", 64'(rsp1_valid), 64'(rv && m_id));
      if (rv && !m_id) begin
        chk("rsp0_result", rsp0_result, m_res);
        chk("rsp0_zero", 64'(rsp0_zero), 64'(m_zero));
        chk("rsp0_err", 64'(rsp0_err), 64'(m_err));
      end
      if (rv && m_id) begin
        chk("rsp1_result", rsp1_result, m_res);
        chk("rsp1_zero", 64'(rsp1_zero), 64'(m_zero));
        chk("rsp1_err", 64'(rsp1_err), 64'(m_err));
      end
      if (lit_seq != lit_done && (lit_ch ? rsp1_valid : rsp0_valid)) begin
        lit_done = lit_seq;
        chk("lit_result", lit_ch ? rsp1_result : rsp0_result, lit_res);
        chk("lit_zero", 64'(lit_ch ? rsp1_zero : rsp0_zero), 64'(lit_zero));
        chk("lit_err", 64'(lit_ch ? rsp1_err : rsp0_err), 64'(lit_err));
      end
      if (tmo_cnt != tmo_seen) begin
        tmo_seen = tmo_cnt;
        checks++;
        errors++;
        $display("FAIL timeout: handshake not seen, want it within bound");
      end
    end
  end

  // sel: 0 req0_ready, 1 req1_ready, 2 rsp0_valid, 3 rsp1_valid
  task automatic wait_for(input int sel);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      case (sel)
        0: ok = req0_ready;
        1: ok = req1_ready;
        2: ok = rsp0_valid;
        default: ok = rsp1_valid;
      endcase
    end
    if (!ok) tmo_cnt++;
  endtask

  task automatic drive(input logic ch, input logic v,
                       input logic [63:0] a, b, input logic [3:0] op);
    if (ch) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  task automatic issue(input logic ch, input logic [63:0] a, b,
                       input logic [3:0] op, input logic [63:0] er,
                       input logic ez, ee);
    lit_ch = ch; lit_res = er; lit_zero = ez; lit_err = ee;
    lit_seq++;
    drive(ch, 1'b1, a, b, op);
    wait_for(ch ? 1 : 0);
    @(posedge clk); #1;
    drive(ch, 1'b0, {$urandom, $urandom}, {$urandom, $urandom},
          4'($urandom));
    wait_for(ch ? 3 : 2);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    issue(0, 64'd5, 64'd3, 4'b0010, 64'd8, 0, 0);
    issue(1, 64'h10, 64'h10, 4'b0110, 64'd0, 1, 0);
    issue(1, 64'd0, 64'd1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    issue(0, 64'd7, 64'd9, 4'b1111, 64'd0, 0, 1);
    issue(0, 64'hF0, 64'h0F, 4'b0001, 64'hFF, 0, 0);
    issue(1, 64'hFF00, 64'h0FF0, 4'b0000, 64'h0F00, 0, 0);

    drive(0, 1'b1, 64'd100, 64'd1, 4'b0010);
    drive(1, 1'b1, 64'd7, 64'd9, 4'b0110);
    n = 0;
    for (int i = 0; i < 200 && n < 8; i++) begin
      @(negedge clk);
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) n++;
    end
    if (n < 8) tmo_cnt++;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    rsp0_ready = 1'b0;
    drive(0, 1'b1, 64'd1, 64'd2, 4'b0010);
    drive(1, 1'b1, 64'd3, 64'd4, 4'b0001);
    wait_for(0);
    @(posedge clk); #1;
    req0_a = 64'hDEAD;
    req0_valid = 1'b0;
    wait_for(2);
    repeat (5) @(posedge clk);
    #1 rsp0_ready = 1'b1;
    wait_for(1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_for(3);
    @(posedge clk); #1;

    issue(0, 64'd6, 64'd7, 4'b0000, 64'd6, 0, 0);

    drive(0, 1'b1, 64'd9, 64'd9, 4'b0010);
    wait_for(0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    drive(1, 1'b1, 64'd1, 64'd1, 4'b0010);
    issue(0, 64'd20, 64'd22, 4'b0010, 64'd42, 0, 0);
    req1_valid = 1'b0;

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
